cia_int: RTL and testbench
==========================

Name: cia_int

Overview:
- Interrupt control register (ICR, reg 0xD) of the 8520 CIA model. Sits directly downstream of the TOD/timer D block, timers A/B, the serial port and the FLAG pin.
- Latches each source's interrupt pulse into a sticky data flag and holds a per-source mask.
- Presents read data {IR,00,flags} on the register bus.
- Drives the CIA's IRQ output toward Paula.

Parameters:
- IRQ_DELAY, 1: number of clk7_en cycles from an enabled flag becoming set to irq assertion. Legal values: 0 (irq combinational from registered state) or 1 (irq registered).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; sampled only when clk7_en=1
- clk7_en  input  1  7 MHz clock enable; all state updates only when high
- wr  input  1  bus write strobe (1=write, 0=read)
- icrs  input  1  ICR register select
- data_in  input  8  bus write data
- data_out  output  8  bus read data; 0 when not selected or when wr=1
- ta  input  1  timer A underflow pulse (bit 0)
- tb  input  1  timer B underflow pulse (bit 1)
- alrm  input  1  TOD alarm (bit 2); may stay high 1–2 clk7_en cycles
- ser  input  1  serial byte complete (bit 3)
- flag  input  1  FLAG pin falling-edge pulse (bit 4)
- irq  output  1  active-high interrupt request

Behaviour:
- State: icr[4:0] (sticky data flags), icrmask[4:0], irq register (when IRQ_DELAY=1).
- Reset: icr=0, icrmask=0, irq=0. data_out is combinational, so it reads 0 / {irq,2'b00,5'b0} per the select rules.
- Flag set: on a clk7_en cycle, any source input high sets its icr bit. Bit order: {flag,ser,alrm,tb,ta}. A level held over several cycles keeps setting the same bit with no other effect.
- Flags are set regardless of mask. The mask gates irq only.
- Read (icrs=1, wr=0): data_out = {irq, 2'b00, icr[4:0]}, combinational from current state.
- Read-clear: on each clk7_en cycle with icrs=1 and wr=0, icr is cleared at that edge.
- Simultaneous read-clear and source event on the same edge: the new event wins. That bit is left set, so it is reported on the next read and no event is lost.
- Write (icrs=1, wr=1) on a clk7_en cycle:
  - data_in[7]=1: icrmask |= data_in[4:0].
  - data_in[7]=0: icrmask &= ~data_in[4:0].
  - Bits 6:5 are ignored. icr is unaffected by writes.
- irq_next = |(icr_next & icrmask_next), using the values after this edge's set/clear/mask updates.
- IRQ_DELAY=1: irq <= irq_next one clk7_en edge later. The edge after the flag is set raises irq, and a read-clear drops irq one edge after the clear.
- IRQ_DELAY=0: irq = |(icr & icrmask), combinational from registers.
- Masking an already-set flag: irq deasserts per the delay rule; the flag stays set.
- Unmasking an already-set flag: irq asserts per the delay rule, with no new event required.
- Reset mid-operation: reset has priority over every update on the same clk7_en edge.
- No state change on clk edges where clk7_en=0, whatever the inputs.

Test Plan (IRQ_DELAY=1 unless stated):
- Reset, then read ICR -> data_out=8'h00, irq=0.
- Write 8'h84 (enable alrm), pulse alrm for 2 clk7_en cycles -> icr=5'b00100; irq=1 one edge later; read returns 8'h84, the following read returns 8'h00; irq low one edge after the clearing read.
- With no mask set, pulse ta -> read returns 8'h01, irq stays 0. Then write 8'h81 -> irq=1 with no new event. Then write 8'h01 -> irq=0 and the flag is still set.
- Read ICR on the same clk7_en edge as a tb pulse -> that read shows tb=0 (or old value); the next read returns bit1=1.
- Mask 8'h9F, pulse all five sources in one cycle, then assert reset on the next edge -> icr=0, icrmask=0, irq=0, and later pulses produce no irq.
- IRQ_DELAY=0: mask ser, pulse ser -> irq high in the same clk7_en cycle in which icr[3] is observed set; toggling inputs with clk7_en=0 -> no state change.

Source files
------------

// File: rtl/cia_int.sv
// 8520 CIA interrupt control register: sticky per-source flags, per-source mask,
// read-clear and the IRQ output toward Paula.

module cia_int_bit (
   input  logic clk,
   input  logic reset,
   input  logic clk7_en,
   input  logic src,
   input  logic rd_clr,
   input  logic wr_mask,
   input  logic mask_set,
   input  logic mask_sel,
   output logic flag,
   output logic mask
);

   // A source event on the same edge as a read-clear wins, so no event is lost.
   always_ff @(posedge clk) begin
      if (clk7_en) begin
         if (reset) begin
            flag <= 1'b0;
            mask <= 1'b0;
         end else begin
            if (src)
               flag <= 1'b1;
            else if (rd_clr)
               flag <= 1'b0;
            if (wr_mask && mask_sel)
               mask <= mask_set;
         end
      end
   end

endmodule

module cia_int #(
   parameter int IRQ_DELAY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic       wr,
   input  logic       icrs,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       ta,
   input  logic       tb,
   input  logic       alrm,
   input  logic       ser,
   input  logic       flag,
   output logic       irq
);

   logic [4:0] srcs;
   logic [4:0] icr;
   logic [4:0] icrmask;
   logic       rd_clr;
   logic       wr_mask;
   logic       unused_bits;

   assign srcs        = {flag, ser, alrm, tb, ta};
   assign rd_clr      = icrs & ~wr;
   assign wr_mask     = icrs & wr;
   assign unused_bits = ^data_in[6:5];

   for (genvar i = 0; i < 5; i++) begin : g_bit
      cia_int_bit u_bit (
         .clk      (clk),
         .reset    (reset),
         .clk7_en  (clk7_en),
         .src      (srcs[i]),
         .rd_clr   (rd_clr),
         .wr_mask  (wr_mask),
         .mask_set (data_in[7]),
         .mask_sel (data_in[i]),
         .flag     (icr[i]),
         .mask     (icrmask[i])
      );
   end

   // Delayed form samples the registered flag/mask state, so irq lags a set or
   // clear by exactly one clk7_en edge.
   if (IRQ_DELAY != 0) begin : g_irq_reg
      logic irq_q;
      always_ff @(posedge clk) begin
         if (clk7_en) begin
            if (reset)
               irq_q <= 1'b0;
            else
               irq_q <= |(icr & icrmask);
         end
      end
      assign irq = irq_q;
   end else begin : g_irq_comb
      assign irq = |(icr & icrmask);
   end

   assign data_out = (icrs && !wr) ? {irq, 2'b00, icr} : 8'h00;

endmodule

// File: tb/tb_cia_int.sv
// Self-checking bench for cia_int: fixed vector table, a hand-written
// read-vs-event sequence, then random traffic against a behavioural model.

module tb_cia_int;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clk7_en = 1'b0;
   logic       wr = 1'b0;
   logic       icrs = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ta = 1'b0, tb = 1'b0, alrm = 1'b0, ser = 1'b0, flag = 1'b0;
   logic [7:0] data_out, data_out0;
   logic       irq, irq0;

   always #5 clk = ~clk;

   cia_int #(.IRQ_DELAY(1)) dut (
      .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .icrs(icrs),
      .data_in(data_in), .data_out(data_out), .ta(ta), .tb(tb), .alrm(alrm),
      .ser(ser), .flag(flag), .irq(irq)
   );

   cia_int #(.IRQ_DELAY(0)) dut0 (
      .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .icrs(icrs),
      .data_in(data_in), .data_out(data_out0), .ta(ta), .tb(tb), .alrm(alrm),
      .ser(ser), .flag(flag), .irq(irq0)
   );

   typedef struct {
      logic       en, rst, wr, icrs;
      logic [7:0] din;
      logic [4:0] src;   // {flag,ser,alrm,tb,ta}
      logic [7:0] dout;  // expected read data before the edge (delayed DUT)
      logic       irq1;  // expected irq after the edge, IRQ_DELAY=1
      logic       irq0;  // expected irq after the edge, IRQ_DELAY=0
   } vec_t;

   vec_t tab[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // behavioural model state
   logic [4:0] m_icr = 5'h0, m_mask = 5'h0;
   logic       m_irq1 = 1'b0;

   function automatic vec_t mk(input logic en, rst, w, sel, input logic [7:0] din,
                               input logic [4:0] src, input logic [7:0] dout,
                               input logic i1, i0);
      vec_t v;
      v.en = en; v.rst = rst; v.wr = w; v.icrs = sel; v.din = din; v.src = src;
      v.dout = dout; v.irq1 = i1; v.irq0 = i0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Inputs are applied just after a falling edge; read data is checked before
   // the rising edge, irq after it.
   task automatic step(input vec_t v, input bit use_tab);
      logic [7:0] m_dout, m_dout0;
      logic       m_irq0;
      clk7_en = v.en; reset = v.rst; wr = v.wr; icrs = v.icrs; data_in = v.din;
      {flag, ser, alrm, tb, ta} = v.src;
      #1;
      m_irq0  = |(m_icr & m_mask);
      m_dout  = (v.icrs && !v.wr) ? {m_irq1, 2'b00, m_icr} : 8'h00;
      m_dout0 = (v.icrs && !v.wr) ? {m_irq0, 2'b00, m_icr} : 8'h00;
      if (use_tab) chk("data_out", data_out, v.dout);
      else begin
         chk("data_out", data_out, m_dout);
         chk("data_out_d0", data_out0, m_dout0);
      end
      @(posedge clk);
      if (v.en) begin
         if (v.rst) begin
            m_icr = 5'h0; m_mask = 5'h0; m_irq1 = 1'b0;
         end else begin
            m_irq1 = |(m_icr & m_mask);
            if (v.icrs && !v.wr) m_icr = 5'h0;
            m_icr = m_icr | v.src;
            if (v.icrs && v.wr)
               m_mask = v.din[7] ? (m_mask | v.din[4:0]) : (m_mask & ~v.din[4:0]);
         end
      end
      @(negedge clk);
      if (use_tab) begin
         chk("irq", {7'b0, irq}, {7'b0, v.irq1});
         chk("irq_d0", {7'b0, irq0}, {7'b0, v.irq0});
      end else begin
         chk("irq", {7'b0, irq}, {7'b0, m_irq1});
         chk("irq_d0", {7'b0, irq0}, {7'b0, |(m_icr & m_mask)});
      end
   endtask

   initial begin
      //                en rst wr sel din    src    dout  i1 i0
      tab.push_back(mk(1, 1, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0)); // reset
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h00, 0, 0)); // read after reset
      tab.push_back(mk(1, 0, 1, 1, 8'h84, 5'h00, 8'h00, 0, 0)); // enable alrm
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h04, 8'h00, 0, 1)); // alrm cycle 1
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h04, 8'h00, 1, 1)); // alrm cycle 2
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h84, 1, 0)); // clearing read
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0));
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h00, 0, 0)); // reads empty
      tab.push_back(mk(1, 0, 1, 1, 8'h04, 5'h00, 8'h00, 0, 0)); // mask all off
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h01, 8'h00, 0, 0)); // ta, masked
      tab.push_back(mk(1, 0, 1, 1, 8'h81, 5'h00, 8'h00, 0, 1)); // unmask ta
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 1, 1));
      tab.push_back(mk(1, 0, 1, 1, 8'h01, 5'h00, 8'h00, 1, 0)); // re-mask ta
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0));
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h01, 0, 0)); // flag survived
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h02, 8'h00, 0, 0)); // read + tb
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h02, 0, 0)); // tb not lost
      tab.push_back(mk(1, 0, 1, 1, 8'h9F, 5'h00, 8'h00, 0, 0)); // mask all
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h1F, 8'h00, 0, 1)); // all sources
      tab.push_back(mk(1, 1, 0, 0, 8'h00, 5'h1F, 8'h00, 0, 0)); // reset wins
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h1F, 8'h00, 0, 0)); // no irq now
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0));
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h1F, 0, 0));
      tab.push_back(mk(1, 0, 1, 1, 8'h88, 5'h00, 8'h00, 0, 0)); // enable ser
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h08, 8'h00, 0, 1)); // ser
      tab.push_back(mk(0, 0, 0, 1, 8'h00, 5'h1F, 8'h08, 0, 1)); // en low: read
      tab.push_back(mk(0, 0, 1, 1, 8'h7F, 5'h00, 8'h00, 0, 1)); // en low: write
      tab.push_back(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h08, 1, 0));
      tab.push_back(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0));

      @(negedge clk);
      foreach (tab[i]) step(tab[i], 1'b1);

      // alrm held two cycles with a read on the second: the event must survive
      step(mk(1, 0, 1, 1, 8'h84, 5'h00, 8'h00, 0, 0), 1'b1);
      step(mk(1, 0, 0, 0, 8'h00, 5'h04, 8'h00, 0, 1), 1'b1);
      step(mk(1, 0, 0, 1, 8'h00, 5'h04, 8'h04, 1, 1), 1'b1);
      step(mk(1, 0, 0, 1, 8'h00, 5'h00, 8'h84, 1, 0), 1'b1);
      step(mk(1, 0, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0), 1'b1);

      // random traffic against the model, from a known reset state
      step(mk(1, 1, 0, 0, 8'h00, 5'h00, 8'h00, 0, 0), 1'b0);
      for (int n = 0; n < 600; n++) begin
         vec_t v;
         logic [4:0] s;
         s = 5'h0;
         for (int b = 0; b < 5; b++) s[b] = ($urandom_range(0, 5) == 0);
         v = mk($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                8'($urandom), s, 8'h00, 0, 0);
         step(v, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
